// File: rtl/mem_arbiter_if.sv
// Cache/memory side bundle of mem_arbiter: both cache request ports, both return ports and the memory port.
interface mem_arbiter_if;
    logic        IRequest;
    logic [15:0] IAddress;
    logic        DRequest;
    logic [15:0] DAddress;
    logic        DWrite;
    logic [15:0] DWriteData;
    logic [15:0] IDataOut;
    logic        IStall;
    logic        IDataValid;
    logic [15:0] DDataOut;
    logic        DStall;
    logic        DDataValid;
    logic        MemEnable;
    logic        MemWrite;
    logic [15:0] MemAddress;
    logic [15:0] MemDataOut;
    logic [15:0] MemDataIn;
    logic        MemDataValid;

    modport slave (
        input  IRequest, IAddress, DRequest, DAddress, DWrite, DWriteData, MemDataIn, MemDataValid,
        output IDataOut, IStall, IDataValid, DDataOut, DStall, DDataValid,
        output MemEnable, MemWrite, MemAddress, MemDataOut
    );

    modport master (
        output IRequest, IAddress, DRequest, DAddress, DWrite, DWriteData, MemDataIn, MemDataValid,
        input  IDataOut, IStall, IDataValid, DDataOut, DStall, DDataValid,
        input  MemEnable, MemWrite, MemAddress, MemDataOut
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one multicycle memory between I-cache and D-cache, holding a grant until its reads drain.
// Define ROUND_ROBIN_EN to alternate winners on simultaneous requests instead of fixed D priority.
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

    state_t        state;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] in_flight_next;
    logic          owner_d;
    logic          can_read;
    logic          ret;
    logic          i_issue;
    logic          d_issue;
    logic          d_wr_issue;
    logic          rd_issue;
    logic          grant_d;

`ifdef ROUND_ROBIN_EN
    logic          last_d;
    assign grant_d = bus.DRequest & (~bus.IRequest | ~last_d);
`else
    assign grant_d = bus.DRequest;
`endif

    always_comb begin
        can_read   = in_flight < CW'(MEM_LATENCY);
        ret        = bus.MemDataValid & (in_flight != '0);
        i_issue    = (state == OWN_I) & bus.IRequest & can_read;
        d_issue    = (state == OWN_D) & bus.DRequest & (bus.DWrite | can_read);
        d_wr_issue = d_issue & bus.DWrite;
        rd_issue   = i_issue | (d_issue & ~bus.DWrite);
        in_flight_next = in_flight;
        if (rd_issue & ~ret)
            in_flight_next = in_flight + CW'(1);
        else if (ret & ~rd_issue)
            in_flight_next = in_flight - CW'(1);
    end

    // Outputs are forced low while reset is held so a mid-burst reset is silent immediately.
    always_comb begin
        bus.IStall     = ~rst & bus.IRequest & ~i_issue;
        bus.DStall     = ~rst & bus.DRequest & ~d_issue;
        bus.MemEnable  = ~rst & (i_issue | d_issue);
        bus.MemWrite   = ~rst & d_wr_issue;
        bus.MemAddress = '0;
        if (~rst & i_issue)
            bus.MemAddress = bus.IAddress;
        else if (~rst & d_issue)
            bus.MemAddress = bus.DAddress;
        bus.MemDataOut = (~rst & d_wr_issue) ? bus.DWriteData : '0;
        bus.IDataValid = ~rst & ret & ~owner_d;
        bus.DDataValid = ~rst & ret & owner_d;
        bus.IDataOut   = bus.IDataValid ? bus.MemDataIn : '0;
        bus.DDataOut   = bus.DDataValid ? bus.MemDataIn : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_flight <= '0;
            owner_d   <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
        end else begin
            in_flight <= in_flight_next;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= OWN_D;
                        owner_d <= 1'b1;
`ifdef ROUND_ROBIN_EN
                        last_d  <= 1'b1;
`endif
                    end else if (bus.IRequest) begin
                        state   <= OWN_I;
                        owner_d <= 1'b0;
`ifdef ROUND_ROBIN_EN
                        last_d  <= 1'b0;
`endif
                    end
                end
                OWN_I: if (~bus.IRequest && in_flight_next == '0) state <= IDLE;
                OWN_D: if (~bus.DRequest && in_flight_next == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
